// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
//   md_op_t    : HI/LO operation presented by the ID/EX register (MD_NONE = no op)
//   md_state_t : control FSM states of ex_muldiv_unit
//   DIV_ITER   : restoring-division iterations before the sign-fix cycle
package muldiv_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_MADD  = 4'd3,
    MD_MADDU = 4'd4,
    MD_MSUB  = 4'd5,
    MD_MSUBU = 4'd6,
    MD_DIV   = 4'd7,
    MD_DIVU  = 4'd8,
    MD_MTHI  = 4'd9,
    MD_MTLO  = 4'd10,
    MD_MFHI  = 4'd11,
    MD_MFLO  = 4'd12
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL     = 2'd1,
    DIV     = 2'd2,
    DIV_FIX = 2'd3
  } md_state_t;

  localparam int DIV_ITER = 32;

  function automatic logic isMulOp(md_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic isDivOp(md_op_t op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  // Signed forms treat both operands as two's complement.
  function automatic logic isSignedOp(md_op_t op);
    return op inside {MD_MULT, MD_MADD, MD_MSUB, MD_DIV};
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative 32-bit restoring divider: 32 radix-2 iterations on operand
// magnitudes followed by one sign-fix cycle in which done is high and
// quotient/remainder carry the final values.
//   clock, reset    : clock, async active-low reset
//   start           : latch dividend/divisor/signedOp and begin
//   abort           : drop the operation in flight
//   done            : high during the sign-fix cycle (results valid)
//   quotient        : truncated toward zero; all ones on divide by zero
//   remainder       : sign of dividend; dividend on divide by zero
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        signedOp,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        active;
  logic [5:0]  iterCnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] divMag;
  logic [31:0] dividendRaw;
  logic        negQuo;
  logic        negRem;
  logic        divZero;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fixPhase;

  assign fixPhase = active && (iterCnt == 6'(DIV_ITER));
  assign shifted  = {rem, quo[31]};
  // rem < divMag keeps a true difference below 2^32, so bit 32 is the borrow.
  assign diff     = shifted - {1'b0, divMag};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active      <= 1'b0;
      iterCnt     <= '0;
      quo         <= '0;
      rem         <= '0;
      divMag      <= '0;
      dividendRaw <= '0;
      negQuo      <= 1'b0;
      negRem      <= 1'b0;
      divZero     <= 1'b0;
    end else if (start) begin
      active      <= 1'b1;
      iterCnt     <= '0;
      quo         <= (signedOp && dividend[31]) ? (-dividend) : dividend;
      divMag      <= (signedOp && divisor[31]) ? (-divisor) : divisor;
      rem         <= '0;
      dividendRaw <= dividend;
      negQuo      <= signedOp && (dividend[31] ^ divisor[31]);
      negRem      <= signedOp && dividend[31];
      divZero     <= (divisor == 32'd0);
    end else if (abort) begin
      active <= 1'b0;
    end else if (active) begin
      if (fixPhase) begin
        active <= 1'b0;
      end else begin
        iterCnt <= iterCnt + 6'd1;
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= shifted[31:0];
          quo <= {quo[30:0], 1'b0};
        end
      end
    end
  end

  // sign-fix stage
  assign done      = fixPhase;
  assign quotient  = divZero ? 32'hFFFF_FFFF : (negQuo ? (-quo) : quo);
  assign remainder = divZero ? dividendRaw   : (negRem ? (-rem) : rem);

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit holding architectural HI/LO.
// Ops are accepted from the ID/EX register and run after the issuing
// instruction has left EX; EX only stalls when another HI/LO op arrives
// while an operation is still in flight.
//   clock, reset      : clock, async active-low reset
//   EX_Stall          : other EX stall sources (gates acceptance only)
//   EX_Flush          : kill in-flight op and the op presented
//   EX_MulDivOp       : md_op_t of the EX instruction
//   EX_ReadData1/2    : rs / rt operands
//   EX_MulDiv_Stall   : HI/LO op presented while busy
//   EX_MulDivBusy     : op in flight
//   EX_HI, EX_LO      : architectural HI/LO
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        EX_Stall,
  input  logic        EX_Flush,
  input  logic [3:0]  EX_MulDivOp,
  input  logic [31:0] EX_ReadData1,
  input  logic [31:0] EX_ReadData2,
  output logic        EX_MulDiv_Stall,
  output logic        EX_MulDivBusy,
  output logic [31:0] EX_HI,
  output logic [31:0] EX_LO
);

  localparam int DIGIT_W = 32 / MUL_CYCLES;

  md_op_t      op;
  md_op_t      mulOp;
  md_state_t   state;
  md_state_t   stateNext;
  logic [5:0]  iterCnt;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [63:0] accNext;
  logic [63:0] mulResult;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic        busy;
  logic        accept;
  logic        lastMul;
  logic        divDone;
  logic [31:0] divQuo;
  logic [31:0] divRem;

  assign op      = md_op_t'(EX_MulDivOp);
  assign busy    = (state != IDLE);
  assign accept  = (op != MD_NONE) && !busy && !EX_Stall && !EX_Flush;
  assign lastMul = (iterCnt == 6'(MUL_CYCLES - 1));

  assign EX_MulDiv_Stall = (op != MD_NONE) && busy;
  assign EX_MulDivBusy   = busy;
  assign EX_HI           = hiReg;
  assign EX_LO           = loReg;

  // One DIGIT_W-bit digit of rt per cycle. For signed ops rt bit 31 carries
  // weight -2^31, so that partial product is subtracted in the last cycle.
  always_comb begin
    accNext = acc;
    for (int j = 0; j < DIGIT_W; j++) begin
      if (mplier[j]) begin
        if (lastMul && isSignedOp(mulOp) && (j == DIGIT_W - 1)) begin
          accNext = accNext - (mcand << j);
        end else begin
          accNext = accNext + (mcand << j);
        end
      end
    end
  end

  always_comb begin
    case (mulOp)
      MD_MADD, MD_MADDU: mulResult = {hiReg, loReg} + accNext;
      MD_MSUB, MD_MSUBU: mulResult = {hiReg, loReg} - accNext;
      default:           mulResult = accNext;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept && isMulOp(op)) begin
          stateNext = MUL;
        end else if (accept && isDivOp(op)) begin
          stateNext = DIV;
        end
      end
      MUL: begin
        if (EX_Flush || lastMul) stateNext = IDLE;
      end
      DIV: begin
        if (EX_Flush) begin
          stateNext = IDLE;
        end else if (iterCnt == 6'(DIV_ITER - 1)) begin
          stateNext = DIV_FIX;
        end
      end
      DIV_FIX: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mulOp   <= MD_NONE;
      iterCnt <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        iterCnt <= '0;
        mulOp   <= op;
        mcand   <= isSignedOp(op) ? {{32{EX_ReadData1[31]}}, EX_ReadData1}
                                  : {32'h0, EX_ReadData1};
        mplier  <= EX_ReadData2;
        acc     <= '0;
        if (op == MD_MTHI) hiReg <= EX_ReadData1;
        if (op == MD_MTLO) loReg <= EX_ReadData1;
      end else if (busy && !EX_Flush) begin
        iterCnt <= iterCnt + 6'd1;
        if (state == MUL) begin
          acc    <= accNext;
          mcand  <= mcand << DIGIT_W;
          mplier <= mplier >> DIGIT_W;
          // write coincides with busy falling so a stalled consumer sees it
          if (lastMul) {hiReg, loReg} <= mulResult;
        end
        if ((state == DIV_FIX) && divDone) {hiReg, loReg} <= {divRem, divQuo};
      end
    end
  end

  muldiv_divider uDivider (
    .clock     (clock),
    .reset     (reset),
    .start     (accept && isDivOp(op)),
    .abort     (EX_Flush && busy),
    .signedOp  (op == MD_DIV),
    .dividend  (EX_ReadData1),
    .divisor   (EX_ReadData2),
    .done      (divDone),
    .quotient  (divQuo),
    .remainder (divRem)
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit (MUL_CYCLES=4): directed scenarios plus a random
// op stream compared against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int MUL_CYCLES = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        EX_Stall = 1'b0;
  logic        EX_Flush = 1'b0;
  logic [3:0]  EX_MulDivOp = 4'd0;
  logic [31:0] EX_ReadData1 = 32'd0;
  logic [31:0] EX_ReadData2 = 32'd0;
  logic        EX_MulDiv_Stall;
  logic        EX_MulDivBusy;
  logic [31:0] EX_HI;
  logic [31:0] EX_LO;

  int nCompared = 0;
  int nMismatch = 0;
  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  ex_muldiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clock           (clock),
    .reset           (reset),
    .EX_Stall        (EX_Stall),
    .EX_Flush        (EX_Flush),
    .EX_MulDivOp     (EX_MulDivOp),
    .EX_ReadData1    (EX_ReadData1),
    .EX_ReadData2    (EX_ReadData2),
    .EX_MulDiv_Stall (EX_MulDiv_Stall),
    .EX_MulDivBusy   (EX_MulDivBusy),
    .EX_HI           (EX_HI),
    .EX_LO           (EX_LO)
  );

  always #5 clock = ~clock;

  // Reference: what HI/LO must hold after op completes.
  task automatic modelOp(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, prod;
    longint sa, sb;
    logic sgn;
    sgn  = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
    ea   = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    eb   = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    prod = ea * eb;
    case (op)
      MD_MULT, MD_MULTU: {modelHi, modelLo} = prod;
      MD_MADD, MD_MADDU: {modelHi, modelLo} = {modelHi, modelLo} + prod;
      MD_MSUB, MD_MSUBU: {modelHi, modelLo} = {modelHi, modelLo} - prod;
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) begin
          modelLo = 32'hFFFF_FFFF;
          modelHi = a;
        end else if (op == MD_DIV) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          modelLo = 32'(sa / sb);
          modelHi = 32'(sa % sb);
        end else begin
          modelLo = a / b;
          modelHi = a % b;
        end
      end
      MD_MTHI: modelHi = a;
      MD_MTLO: modelLo = a;
      default: ;
    endcase
  endtask

  function automatic int expBusy(input md_op_t op);
    if (op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU}) return MUL_CYCLES;
    if (op inside {MD_DIV, MD_DIVU}) return 33;
    return 0;
  endfunction

  // Called at a negedge; presents op for one edge, returns at the next negedge.
  task automatic issueOp(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    EX_MulDivOp  = op;
    EX_ReadData1 = a;
    EX_ReadData2 = b;
    @(negedge clock);
    EX_MulDivOp = MD_NONE;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (EX_MulDivBusy && n < 100) begin
      n++;
      @(negedge clock);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic md_op_t randOp();
    case ($urandom_range(0, 9))
      0: return MD_MULT;
      1: return MD_MULTU;
      2: return MD_MADD;
      3: return MD_MADDU;
      4: return MD_MSUB;
      5: return MD_MSUBU;
      6: return MD_DIV;
      7: return MD_DIVU;
      8: return MD_MTHI;
      default: return MD_MTLO;
    endcase
  endfunction

  task automatic test_reset();
    EX_MulDivOp = MD_MULT;
    EX_ReadData1 = 32'h5;
    EX_ReadData2 = 32'h7;
    @(negedge clock);
    @(negedge clock);
    nCompared++;
    if (EX_MulDivBusy !== 1'b0) begin nMismatch++; $display("FAIL reset_busy actual=%b required=0", EX_MulDivBusy); end
    nCompared++;
    if (EX_MulDiv_Stall !== 1'b0) begin nMismatch++; $display("FAIL reset_stall actual=%b required=0", EX_MulDiv_Stall); end
    nCompared++;
    if ({EX_HI, EX_LO} !== 64'd0) begin nMismatch++; $display("FAIL reset_hilo actual=%h required=0", {EX_HI, EX_LO}); end
    EX_MulDivOp = MD_NONE;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic runChecked(input string name, input md_op_t op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] required);
    int n;
    modelOp(op, a, b);
    issueOp(op, a, b);
    waitIdle(n);
    nCompared++;
    if (n !== expBusy(op)) begin nMismatch++; $display("FAIL %s_busy actual=%0d required=%0d", name, n, expBusy(op)); end
    nCompared++;
    if ({EX_HI, EX_LO} !== required) begin nMismatch++; $display("FAIL %s_hilo actual=%h required=%h", name, {EX_HI, EX_LO}, required); end
  endtask

  task automatic test_directed();
    runChecked("mult",    MD_MULT,  32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE);
    runChecked("multu",   MD_MULTU, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE);
    runChecked("div_neg", MD_DIV,   32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
    runChecked("div_ovf", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    runChecked("divu_z",  MD_DIVU,  32'h0000_1234, 32'h0, 64'h0000_1234_FFFF_FFFF);
    runChecked("mthi",    MD_MTHI,  32'h0, 32'h0, 64'h0000_0000_FFFF_FFFF);
    runChecked("mtlo",    MD_MTLO,  32'hFFFF_FFFF, 32'h0, 64'h0000_0000_FFFF_FFFF);
    runChecked("maddu",   MD_MADDU, 32'h1, 32'h1, 64'h0000_0001_0000_0000);
  endtask

  task automatic test_consumer_stall();
    int n;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom_range(1, 1000);
    modelOp(MD_DIVU, a, b);
    issueOp(MD_DIVU, a, b);
    @(negedge clock);
    EX_MulDivOp = MD_MFLO;
    #1;
    n = 0;
    while (EX_MulDiv_Stall && n < 100) begin
      n++;
      @(negedge clock);
    end
    nCompared++;
    if (n !== 32) begin nMismatch++; $display("FAIL mflo_stall_cycles actual=%0d required=32", n); end
    nCompared++;
    if (EX_LO !== modelLo) begin nMismatch++; $display("FAIL mflo_fresh_lo actual=%h required=%h", EX_LO, modelLo); end
    EX_MulDivOp = MD_NONE;
    @(negedge clock);

    // MULT waiting behind a divide
    a = $urandom;
    b = $urandom;
    modelOp(MD_DIV, a, b);
    issueOp(MD_DIV, a, b);
    EX_MulDivOp  = MD_MULT;
    EX_ReadData1 = 32'h0001_0003;
    EX_ReadData2 = 32'hFFFF_FFF0;
    #1;
    n = 0;
    while (EX_MulDiv_Stall && n < 100) begin
      n++;
      @(negedge clock);
    end
    nCompared++;
    if ({EX_MulDivBusy, EX_HI, EX_LO} !== {1'b0, modelHi, modelLo}) begin
      nMismatch++;
      $display("FAIL div_before_mult actual=%b/%h required=0/%h", EX_MulDivBusy, {EX_HI, EX_LO}, {modelHi, modelLo});
    end
    @(negedge clock);
    nCompared++;
    if (EX_MulDivBusy !== 1'b1) begin nMismatch++; $display("FAIL mult_accept_late actual=%b required=1", EX_MulDivBusy); end
    EX_MulDivOp = MD_NONE;
    modelOp(MD_MULT, 32'h0001_0003, 32'hFFFF_FFF0);
    waitIdle(n);
    nCompared++;
    if (n !== MUL_CYCLES) begin nMismatch++; $display("FAIL mult_queued_busy actual=%0d required=%0d", n, MUL_CYCLES); end
    nCompared++;
    if ({EX_HI, EX_LO} !== {modelHi, modelLo}) begin nMismatch++; $display("FAIL mult_queued_hilo actual=%h required=%h", {EX_HI, EX_LO}, {modelHi, modelLo}); end
  endtask

  task automatic test_flush();
    logic [31:0] v;
    issueOp(MD_DIV, 32'h1234_5678, 32'h0000_0013);
    repeat (9) @(negedge clock);
    EX_Flush = 1'b1;
    @(negedge clock);
    EX_Flush = 1'b0;
    nCompared++;
    if (EX_MulDivBusy !== 1'b0) begin nMismatch++; $display("FAIL div_flush_busy actual=%b required=0", EX_MulDivBusy); end
    nCompared++;
    if ({EX_HI, EX_LO} !== {modelHi, modelLo}) begin nMismatch++; $display("FAIL div_flush_hilo actual=%h required=%h", {EX_HI, EX_LO}, {modelHi, modelLo}); end

    issueOp(MD_MULT, 32'h0000_0007, 32'h0000_0009);
    repeat (3) @(negedge clock);
    EX_Flush = 1'b1;
    @(negedge clock);
    EX_Flush = 1'b0;
    nCompared++;
    if ({EX_MulDivBusy, EX_HI, EX_LO} !== {1'b0, modelHi, modelLo}) begin
      nMismatch++;
      $display("FAIL mult_flush_last actual=%b/%h required=0/%h", EX_MulDivBusy, {EX_HI, EX_LO}, {modelHi, modelLo});
    end

    v = modelHi ^ 32'hA5A5_0F0F;
    EX_Flush = 1'b1;
    issueOp(MD_MTHI, v, 32'h0);
    EX_Flush = 1'b0;
    nCompared++;
    if (EX_HI !== modelHi) begin nMismatch++; $display("FAIL mthi_flush actual=%h required=%h", EX_HI, modelHi); end
  endtask

  task automatic test_async_reset();
    int n;
    modelOp(MD_MTHI, 32'hCAFE_0001, 32'h0);
    issueOp(MD_MTHI, 32'hCAFE_0001, 32'h0);
    issueOp(MD_MULT, 32'h0000_0003, 32'h0000_0005);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    modelHi = 32'd0;
    modelLo = 32'd0;
    nCompared++;
    if ({EX_MulDivBusy, EX_HI, EX_LO} !== 65'd0) begin
      nMismatch++;
      $display("FAIL async_reset actual=%b/%h required=0/0", EX_MulDivBusy, {EX_HI, EX_LO});
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    runChecked("post_reset", MD_MULTU, 32'h0000_0003, 32'h0000_0005, 64'd15);
    n = 0;
  endtask

  task automatic test_ex_stall();
    int n;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom_range(1, 100000);
    modelOp(MD_DIV, a, b);
    issueOp(MD_DIV, a, b);
    EX_Stall = 1'b1;
    waitIdle(n);
    nCompared++;
    if (n !== 33) begin nMismatch++; $display("FAIL stall_div_busy actual=%0d required=33", n); end
    nCompared++;
    if ({EX_HI, EX_LO} !== {modelHi, modelLo}) begin nMismatch++; $display("FAIL stall_div_hilo actual=%h required=%h", {EX_HI, EX_LO}, {modelHi, modelLo}); end
    issueOp(MD_MULTU, 32'h0000_1111, 32'h0000_2222);
    nCompared++;
    if ({EX_MulDivBusy, EX_HI, EX_LO} !== {1'b0, modelHi, modelLo}) begin
      nMismatch++;
      $display("FAIL stall_blocks_accept actual=%b/%h required=0/%h", EX_MulDivBusy, {EX_HI, EX_LO}, {modelHi, modelLo});
    end
    EX_Stall = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      md_op_t op;
      logic [31:0] a, b;
      int n;
      op = randOp();
      a  = pick();
      b  = pick();
      modelOp(op, a, b);
      issueOp(op, a, b);
      waitIdle(n);
      nCompared++;
      if (n !== expBusy(op)) begin nMismatch++; $display("FAIL rand%0d_busy op=%0d actual=%0d required=%0d", i, op, n, expBusy(op)); end
      nCompared++;
      if ({EX_HI, EX_LO} !== {modelHi, modelLo}) begin
        nMismatch++;
        $display("FAIL rand%0d_hilo op=%0d a=%h b=%h actual=%h required=%h", i, op, a, b, {EX_HI, EX_LO}, {modelHi, modelLo});
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_directed();
    test_consumer_stall();
    test_flush();
    test_async_reset();
    test_ex_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
